// File: rtl/ucsbece154b_mem_arbiter_if.sv
// Bundle of request/response and memory-port signals around the memory arbiter.
// slave is the arbiter's view; master is the view of the clients plus memory.
interface ucsbece154b_mem_arbiter_if #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);

    logic              ireq_i;
    logic [ADDR_W-1:0] iaddr_i;
    logic              igrant_o;
    logic              ivalid_o;
    logic [IDX_W-1:0]  iword_o;
    logic [DATA_W-1:0] idata_o;
    logic              idone_o;

    logic              dreq_i;
    logic              dwe_i;
    logic [ADDR_W-1:0] daddr_i;
    logic [DATA_W-1:0] dwdata_i;
    logic              dgrant_o;
    logic              dvalid_o;
    logic [DATA_W-1:0] drdata_o;
    logic              ddone_o;

    logic              mem_req_o;
    logic              mem_ready_i;
    logic              mem_we_o;
    logic              mem_burst_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_wack_i;

    modport slave (
        input  ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_wack_i,
        output igrant_o, ivalid_o, iword_o, idata_o, idone_o,
               dgrant_o, dvalid_o, drdata_o, ddone_o,
               mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output ireq_i, iaddr_i, dreq_i, dwe_i, daddr_i, dwdata_i,
               mem_ready_i, mem_rvalid_i, mem_rdata_i, mem_wack_i,
        input  igrant_o, ivalid_o, iword_o, idata_o, idone_o,
               dgrant_o, dvalid_o, drdata_o, ddone_o,
               mem_req_o, mem_we_o, mem_burst_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/ucsbece154b_mem_arbiter.sv
// Single-port main-memory arbiter between icache refill (burst reads) and the
// data interface (single-word reads/writes). One transaction in flight; the
// winner's address/data are latched on grant, returned data is steered
// combinationally to the owner with no added latency.
//
//   state | meaning
//   IDLE  | no owner; pick a requester (alternate on contention)
//   ISSUE | mem_req_o held with latched request until mem_ready_i
//   WAIT  | collect read beats or the write ack, then release
//
// The interface parameters must match the module parameters.
module ucsbece154b_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    ucsbece154b_mem_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(BLOCK_WORDS);
    localparam logic [IDX_W-1:0] BEAT_LAST = IDX_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            last_q,  last_d;
    logic [IDX_W-1:0]  beat_q,  beat_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              we_q,    we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    // State and latched-request registers; last starts at I so D wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            owner_q <= OWN_I;
            last_q  <= OWN_I;
            beat_q  <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
        end
    end

    // Arbitration, next-state and output steering.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;

        bus.igrant_o    = (state_q != S_IDLE) && (owner_q == OWN_I);
        bus.dgrant_o    = (state_q != S_IDLE) && (owner_q == OWN_D);
        bus.ivalid_o    = 1'b0;
        bus.iword_o     = '0;
        bus.idata_o     = '0;
        bus.idone_o     = 1'b0;
        bus.dvalid_o    = 1'b0;
        bus.drdata_o    = '0;
        bus.ddone_o     = 1'b0;
        bus.mem_req_o   = 1'b0;
        bus.mem_we_o    = 1'b0;
        bus.mem_burst_o = 1'b0;
        bus.mem_addr_o  = addr_q;
        bus.mem_wdata_o = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.ireq_i || bus.dreq_i) begin
                    if (bus.dreq_i && (!bus.ireq_i || last_q == OWN_I)) begin
                        owner_d = OWN_D;
                        last_d  = OWN_D;
                        addr_d  = bus.daddr_i;
                        we_d    = bus.dwe_i;
                        wdata_d = bus.dwdata_i;
                    end else begin
                        owner_d = OWN_I;
                        last_d  = OWN_I;
                        addr_d  = bus.iaddr_i;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
                    beat_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                bus.mem_req_o   = 1'b1;
                bus.mem_we_o    = we_q;
                bus.mem_burst_o = (owner_q == OWN_I);
                if (bus.mem_ready_i) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (owner_q == OWN_I) begin
                    if (bus.mem_rvalid_i) begin
                        bus.ivalid_o = 1'b1;
                        bus.iword_o  = beat_q;
                        bus.idata_o  = bus.mem_rdata_i;
                        beat_d       = beat_q + IDX_W'(1);
                        if (beat_q == BEAT_LAST) begin
                            bus.idone_o = 1'b1;
                            state_d     = S_IDLE;
                        end
                    end
                end else if (we_q) begin
                    if (bus.mem_wack_i) begin
                        bus.ddone_o = 1'b1;
                        state_d     = S_IDLE;
                    end
                end else if (bus.mem_rvalid_i) begin
                    bus.dvalid_o = 1'b1;
                    bus.drdata_o = bus.mem_rdata_i;
                    bus.ddone_o  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: doc/ucsbece154b_mem_arbiter.md
# ucsbece154b_mem_arbiter

Arbitrates the single main-memory port between the instruction-cache refill engine and the data-memory interface of the pipelined RISC-V core. It accepts one transaction at a time, latches its address and data, issues it to memory and steers returned words back to the owner. Instruction refills are BLOCK_WORDS-beat bursts; data accesses are single-word reads or writes.

## Interface
- BLOCK_WORDS, 4: words per icache line and refill burst length; power of two, ≥2.
- ADDR_W, 32: address width.
- DATA_W, 32: data word width.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ireq_i  in  1  icache refill request; held high until idone_o.
- iaddr_i  in  ADDR_W  refill line address, block-aligned.
- igrant_o  out  1  icache owns the port.
- ivalid_o  out  1  idata_o holds a refill word this cycle.
- iword_o  out  log2(BLOCK_WORDS)  word index within the line for ivalid_o.
- idata_o  out  DATA_W  refill word.
- idone_o  out  1  one-cycle pulse on the last refill word.
- dreq_i  in  1  data request; held high until ddone_o.
- dwe_i  in  1  1 = write, 0 = read.
- daddr_i  in  ADDR_W  word address.
- dwdata_i  in  DATA_W  write data.
- dgrant_o  out  1  data side owns the port.
- dvalid_o  out  1  drdata_o valid (reads only).
- drdata_o  out  DATA_W  read data.
- ddone_o  out  1  one-cycle pulse on completion (read beat or write ack).
- mem_req_o  out  1  request to memory; held until accepted.
- mem_ready_i  in  1  memory accepts mem_req_o this cycle.
- mem_we_o  out  1  write request.
- mem_burst_o  out  1  1 = BLOCK_WORDS-beat read, 0 = single word.
- mem_addr_o  out  ADDR_W  latched request address.
- mem_wdata_o  out  DATA_W  latched write data.
- mem_rvalid_i  in  1  read beat valid.
- mem_rdata_i  in  DATA_W  read beat data.
- mem_wack_i  in  1  write completed.

## Operation
- States IDLE, ISSUE, WAIT; registers owner (I/D), last (last served owner), beat counter, latched addr/we/wdata.
- IDLE: if only one request is high, it wins; if both are high, the requester ≠ last wins. On the edge: latch address (and dwe_i/dwdata_i for D), set owner and last, clear beat counter, go to ISSUE.
- ISSUE: mem_req_o=1 with latched mem_addr_o/mem_we_o/mem_wdata_o; mem_burst_o=1 iff owner=I. When mem_ready_i=1, go to WAIT on the next edge.
- WAIT, owner I: each mem_rvalid_i drives ivalid_o=1, idata_o=mem_rdata_i, iword_o=beat count, then increments the count. The beat with count=BLOCK_WORDS-1 also drives idone_o=1 and returns to IDLE.
- WAIT, owner D read: the first mem_rvalid_i drives dvalid_o=1, drdata_o=mem_rdata_i, ddone_o=1 and returns to IDLE.
- WAIT, owner D write: mem_wack_i drives ddone_o=1 and returns to IDLE.
- Grant: igrant_o/dgrant_o = (state≠IDLE) & owner match. Exactly one grant or none.
- Transactions are never aborted. A wrong-path icache refill after misprediction completes in full. A requester dropping req mid-transaction has no effect.
- Ignored inputs: mem_rvalid_i and mem_wack_i in IDLE or ISSUE; mem_wack_i while owner=I; mem_rvalid_i while owner=D write.
- Beat counter is log2(BLOCK_WORDS) bits and wraps to 0 on the last beat.

## Timing
- Reset: state IDLE, last=I (D wins the first contention), counter 0, all outputs 0 including mem_addr_o, mem_wdata_o, idata_o, drdata_o.
- Reset mid-transaction returns to IDLE on that edge. Beats arriving afterwards are ignored.
- Request sampled high at edge N → grant and mem_req_o high from cycle N+1.
- mem_req_o deasserts the cycle after the mem_ready_i handshake cycle.
- ivalid_o, dvalid_o and done pulses are combinational from mem_* inputs in WAIT; there is zero added latency on returned data.
- After done, the arbiter is in IDLE for exactly one cycle before the next grant. Minimum gap from done to the next mem_req_o is 2 cycles.
- Address and data inputs are sampled only at the IDLE→ISSUE edge; later changes are ignored.
- Simultaneous done and new request: the request is sampled in the following IDLE cycle, not in the done cycle.

## Test plan
- I-only refill: ireq_i=1, iaddr_i=0x100, mem_ready_i=1, four beats 0xA0..0xA3 with a stall cycle between beats 2 and 3 → mem_burst_o=1, mem_addr_o=0x100; iword_o 0,1,2,3 with matching data; idone_o only on 0xA3; igrant_o low the cycle after.
- Contention after reset: ireq_i and dreq_i rise together (D read 0x200) → D served first; then I gets the grant. A second simultaneous request pair after that → D served, strictly alternating.
- D write: dwe_i=1, daddr_i=0x44, dwdata_i=0xDEADBEEF; mem_ready_i low 3 cycles, then mem_wack_i after 2 → mem_req_o held 4 cycles with stable addr/data; ddone_o on the ack cycle; dvalid_o never high.
- Stray inputs: pulse mem_rvalid_i and mem_wack_i in IDLE and during an I burst (wack) → no valid/done outputs, no state change, beat count unaffected.
- Reset mid-burst after 2 beats → all outputs 0 next cycle. A following refill to 0x300 starts at iword_o=0 and completes normally.
- Wrong-path refill: ireq_i drops after beat 1 → burst still completes, with idone_o on beat 3.
